cp0_param: RTL and testbench



---
 rtl/cp0_pkg.sv | 30 +++
 rtl/cp0_timer.sv | 26 ++
 rtl/cp0_param.sv | 119 +++++++++++
 tb/tb_cp0_param.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, SR/Cause field positions and
// exception codes used by the pipeline and the coprocessor.
package cp0_pkg;
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam int SR_IE         = 0;
  localparam int SR_EXL        = 1;
  localparam int IM_LSB        = 10;
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_EXC_LSB = 2;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;

  // Return address for a victim: step back over the branch when in a delay slot.
  function automatic logic [31:2] epc_of(input logic [31:0] pc, input logic bd);
    logic [31:0] v;
    v = bd ? (pc - 32'd4) : pc;
    return v[31:2];
  endfunction
endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running counter with a sticky match flag
// cleared only by a Compare write.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        tpend
);
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      compare <= 32'hFFFF_FFFF;
      tpend   <= 1'b0;
    end else begin
      count <= cnt_we ? wdata : count + 32'd1;
      if (cmp_we) compare <= wdata;
      // match is taken on the pre-increment value
      if (cmp_we)                tpend <= 1'b0;
      else if (count == compare) tpend <= 1'b1;
    end
  end
endmodule

// File: rtl/cp0_param.sv
// Parametrised coprocessor 0: SR/Cause/EPC/PRId, optional timer, and the
// exception/interrupt arbitration that redirects fetch to the handler.
module cp0_param
  import cp0_pkg::*;
#(
  parameter int          HWINT_W    = 6,
  parameter bit          TIMER_EN   = 1'b1,
  parameter int          TIMER_LINE = 0,
  parameter logic [31:0] PRID       = 32'h2025_0007,
  parameter logic [31:0] HANDLER    = 32'h0000_4180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         A1,
  input  logic [4:0]         A2,
  input  logic [31:0]        DIn,
  input  logic               CPWr,
  input  logic [31:0]        VPC,
  input  logic               BDIn,
  input  logic [4:0]         ExcCodeIn,
  input  logic [HWINT_W-1:0] HWInt,
  input  logic               EXLClr,
  output logic [31:0]        DOut,
  output logic               Req,
  output logic [31:0]        EPCOut,
  output logic [31:0]        HandlerPC
);
  logic [HWINT_W-1:0] im, ip, eff, tline;
  logic               exl, ie, bd;
  logic [4:0]         exc_code;
  logic [31:2]        epc;
  logic [31:0]        count, compare;
  logic               tpend;
  logic               int_req, exc_req, wr;

  // mtc0 is dropped whenever the instruction is being squashed by Req
  assign wr = CPWr & ~Req;

  generate
    if (TIMER_EN) begin : g_timer
      cp0_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .cnt_we  (wr && A2 == CP0_COUNT),
        .cmp_we  (wr && A2 == CP0_COMPARE),
        .wdata   (DIn),
        .count   (count),
        .compare (compare),
        .tpend   (tpend)
      );
    end else begin : g_no_timer
      assign count   = '0;
      assign compare = '0;
      assign tpend   = 1'b0;
    end
  endgenerate

  always_comb begin
    tline             = '0;
    tline[TIMER_LINE] = tpend;
  end

  assign eff     = HWInt | tline;
  assign int_req = ie & ~exl & (|(eff & im));
  assign exc_req = ~exl & (ExcCodeIn != EXCCODE_INT);
  assign Req     = int_req | exc_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      ip       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= eff;
      if (Req) begin
        exl      <= 1'b1;
        bd       <= BDIn;
        exc_code <= int_req ? EXCCODE_INT : ExcCodeIn;
        epc      <= epc_of(VPC, BDIn);
      end else begin
        if (EXLClr)                    exl <= 1'b0;
        else if (wr && A2 == CP0_SR)   exl <= DIn[SR_EXL];
        if (wr && A2 == CP0_SR) begin
          im <= DIn[IM_LSB +: HWINT_W];
          ie <= DIn[SR_IE];
        end
        if (wr && A2 == CP0_EPC) epc <= DIn[31:2];
      end
    end
  end

  always_comb begin
    DOut = '0;
    case (A1)
      CP0_COUNT:   DOut = count;
      CP0_COMPARE: DOut = compare;
      CP0_SR: begin
        DOut[IM_LSB +: HWINT_W] = im;
        DOut[SR_EXL]            = exl;
        DOut[SR_IE]             = ie;
      end
      CP0_CAUSE: begin
        DOut[CAUSE_BD]               = bd;
        DOut[IM_LSB +: HWINT_W]      = ip;
        DOut[CAUSE_EXC_LSB +: 5]     = exc_code;
      end
      CP0_EPC:     DOut = {epc, 2'b00};
      CP0_PRID:    DOut = PRID;
      default:     DOut = '0;
    endcase
  end

  assign EPCOut    = {epc, 2'b00};
  assign HandlerPC = HANDLER;
endmodule

// File: tb/tb_cp0_param.sv
// Directed-vector bench for cp0_param with hand-computed expectations.
module tb_cp0_param;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, ExcCodeIn;
  logic [31:0] DIn, VPC;
  logic        CPWr, BDIn, EXLClr;
  logic [5:0]  HWInt;
  logic [31:0] DOut, EPCOut, HandlerPC;
  logic        Req;
  int          checks = 0;
  int          errors = 0;

  cp0_param dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .CPWr(CPWr),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .DOut(DOut), .Req(Req), .EPCOut(EPCOut),
    .HandlerPC(HandlerPC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    A1 = a;
    #1;
    chk(tag, DOut, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    A2 = a; DIn = d; CPWr = 1'b1;
    step();
    CPWr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; A1 = '0; A2 = '0; DIn = '0; CPWr = 1'b0; VPC = '0;
    BDIn = 1'b0; ExcCodeIn = '0; HWInt = '0; EXLClr = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    rd(5'd15, "prid", 32'h2025_0007);
    rd(5'd12, "sr_rst", 32'h0);
    rd(5'd13, "cause_rst", 32'h0);
    rd(5'd14, "epc_rst", 32'h0);
    chk("req_rst", {31'b0, Req}, 32'd0);
    chk("epcout_rst", EPCOut, 32'h0);
    chk("handler", HandlerPC, 32'h0000_4180);

    // interrupt on line 2
    mtc0(5'd12, 32'h0000_FC01);
    rd(5'd12, "sr_wr", 32'h0000_FC01);
    HWInt = 6'b000100;
    #1 chk("int_req", {31'b0, Req}, 32'd1);
    step();
    rd(5'd13, "cause_int", 32'h0000_1000);
    rd(5'd12, "sr_exl", 32'h0000_FC03);
    chk("req_in_exl", {31'b0, Req}, 32'd0);
    HWInt = '0; EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    rd(5'd12, "sr_eret", 32'h0000_FC01);

    // AdEL in a delay slot
    ExcCodeIn = 5'd4; VPC = 32'h3010; BDIn = 1'b1;
    #1 chk("exc_req", {31'b0, Req}, 32'd1);
    step();
    ExcCodeIn = '0; BDIn = 1'b0;
    chk("epc_bd", EPCOut, 32'h300C);
    rd(5'd13, "cause_adel", 32'h8000_0010);

    // EXLClr alone, then EXLClr together with an exception: Req wins
    EXLClr = 1'b1;
    step();
    rd(5'd12, "sr_clr", 32'h0000_FC01);
    ExcCodeIn = 5'd10; VPC = 32'h5004;
    step();
    EXLClr = 1'b0; ExcCodeIn = '0;
    rd(5'd12, "sr_req_wins", 32'h0000_FC03);
    chk("epc_reload", EPCOut, 32'h5004);
    rd(5'd13, "cause_ri", 32'h0000_0028);

    // interrupt beats exception; mtc0 in the Req cycle is discarded
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    ExcCodeIn = 5'd4; HWInt = 6'b000100; BDIn = 1'b1; VPC = 32'h6000;
    A2 = 5'd14; DIn = 32'h1234; CPWr = 1'b1;
    step();
    CPWr = 1'b0; ExcCodeIn = '0; HWInt = '0; BDIn = 1'b0;
    rd(5'd13, "cause_prio", 32'h8000_1000);
    chk("epc_discard", EPCOut, 32'h5FFC);

    // Cause is read-only; EPC low bits forced; same-cycle read sees old value
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, "cause_ro", 32'h8000_0000);
    mtc0(5'd14, 32'h3003);
    chk("epc_align", EPCOut, 32'h3000);
    A1 = 5'd14; A2 = 5'd14; DIn = 32'h7000; CPWr = 1'b1;
    #1 chk("no_bypass", DOut, 32'h3000);
    step();
    CPWr = 1'b0;
    rd(5'd14, "wr_then_rd", 32'h7000);

    // timer on line 0 (IM[10] already enabled)
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'h5);
    rd(5'd9, "count_run", 32'h1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("tmr_quiet%0d", i), {31'b0, Req}, 32'd0);
    end
    step();
    chk("tmr_req", {31'b0, Req}, 32'd1);
    step();
    chk("tmr_exl", {31'b0, Req}, 32'd0);
    mtc0(5'd11, 32'h100);
    rd(5'd13, "ip_pre_clr", 32'h0000_0400);
    step();
    rd(5'd13, "ip_cleared", 32'h0);
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    chk("tmr_req_gone", {31'b0, Req}, 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, "count_max", 32'hFFFF_FFFF);
    step();
    rd(5'd9, "count_wrap", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
